// File: rtl/maze_pkg.sv
// ----------------------------------------------------------------------------
// maze_pkg
//   Shared constants and types for the maze map memory.
//   MAP_DIM  : maze side length in cells (map is MAP_DIM x MAP_DIM bits)
//   COORD_W  : coordinate width, log2(MAP_DIM)
//   map_state_e : controller states (IDLE accepts traffic, CLEAR wipes map)
// ----------------------------------------------------------------------------
package maze_pkg;

  localparam int MAP_DIM = 16;
  localparam int COORD_W = $clog2(MAP_DIM);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } map_state_e;

endpackage : maze_pkg

// File: rtl/maze_map_array.sv
// ----------------------------------------------------------------------------
// maze_map_array
//   MAP_DIM x MAP_DIM one-bit register array with async reset.
//   Ports:
//     clk, rst_n              : clock, async active-low reset
//     row_we/row_addr/row_data: full-row write port
//     bit_we/bit_x/bit_y/bit_data : single-cell write port (wins over the
//                               row port for its own cell)
//     rd_en/rd_x/rd_y         : single-cell read request
//     rd_data                 : registered read data, held between reads
//   Cell (x,y) lives at mem_q[y][x].
// ----------------------------------------------------------------------------
module maze_map_array #(
  parameter int MAP_DIM = maze_pkg::MAP_DIM,
  parameter int COORD_W = maze_pkg::COORD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               row_we,
  input  logic [COORD_W-1:0] row_addr,
  input  logic [MAP_DIM-1:0] row_data,
  input  logic               bit_we,
  input  logic [COORD_W-1:0] bit_x,
  input  logic [COORD_W-1:0] bit_y,
  input  logic               bit_data,
  input  logic               rd_en,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic               rd_data
);

  logic [MAP_DIM-1:0][MAP_DIM-1:0] mem_q, mem_d;
  logic                            rd_data_q, rd_data_d;

  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    if (row_we) begin
      mem_d[row_addr] = row_data;
    end
    // Applied after the row write so a same-cycle cell write overrides
    // just that cell of the incoming row.
    if (bit_we) begin
      mem_d[bit_y][bit_x] = bit_data;
    end
    // Reads sample the current contents, so a same-edge write is not seen.
    if (rd_en) begin
      rd_data_d = mem_q[rd_y][rd_x];
    end
  end

  // NOTE: the storage is built from flops, not a RAM macro, so it can be
  // cleared by the async reset; a RAM-inferred array could not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '0;
      rd_data_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule : maze_map_array

// File: rtl/maze_map_memory.sv
// ----------------------------------------------------------------------------
// maze_map_memory
//   Maze occupancy map with a mouse bit port, a host row-load port and a
//   full-map clear sequencer.
//   Ports:
//     CLK, RST                : clock, async active-low reset
//     poseX, poseY, RD, WR    : mouse cell address and read/write requests
//     Dout / Din              : mouse write data / registered read data
//     ldValid, ldRow, ldData  : host row offer; ldReady accepts it
//     clrStart                : request a clear (one row per cycle)
//     Ready                   : high while IDLE; mouse accesses honoured
// ----------------------------------------------------------------------------
module maze_map_memory #(
  parameter int MAP_DIM = maze_pkg::MAP_DIM,
  parameter int COORD_W = maze_pkg::COORD_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [COORD_W-1:0] poseX,
  input  logic [COORD_W-1:0] poseY,
  input  logic               RD,
  input  logic               WR,
  input  logic               Dout,
  output logic               Din,
  input  logic               ldValid,
  input  logic [COORD_W-1:0] ldRow,
  input  logic [MAP_DIM-1:0] ldData,
  output logic               ldReady,
  input  logic               clrStart,
  output logic               Ready
);

  import maze_pkg::*;

  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(MAP_DIM - 1);

  map_state_e         state_q, state_d;
  logic [COORD_W-1:0] clr_cnt_q, clr_cnt_d;

  logic               is_idle;
  logic               is_clear;
  logic               row_we;
  logic [COORD_W-1:0] row_addr;
  logic [MAP_DIM-1:0] row_data;

  assign is_idle  = (state_q == IDLE);
  assign is_clear = (state_q == CLEAR);
  assign Ready    = is_idle;
  // A pending clear refuses the row so the host retries after the wipe.
  assign ldReady  = is_idle && !clrStart;

  // NOTE: every output of this block gets a default first so no path
  // through the case leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clrStart) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ROW) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The row port is shared: the clear sequencer owns it in CLEAR, the host
  // load owns it in IDLE. The two can never overlap.
  assign row_we   = is_clear || (ldValid && ldReady);
  assign row_addr = is_clear ? clr_cnt_q : ldRow;
  assign row_data = is_clear ? '0 : ldData;

  maze_map_array #(
    .MAP_DIM (MAP_DIM),
    .COORD_W (COORD_W)
  ) u_array (
    .clk      (CLK),
    .rst_n    (RST),
    .row_we   (row_we),
    .row_addr (row_addr),
    .row_data (row_data),
    .bit_we   (is_idle && WR),
    .bit_x    (poseX),
    .bit_y    (poseY),
    .bit_data (Dout),
    .rd_en    (is_idle && RD),
    .rd_x     (poseX),
    .rd_y     (poseY),
    .rd_data  (Din)
  );

endmodule : maze_map_memory

// File: tb/tb_maze_map_memory.sv
// ----------------------------------------------------------------------------
// tb_maze_map_memory
//   Directed self-checking bench for maze_map_memory. Inputs change 1 ns
//   after each rising edge; outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_maze_map_memory;

  localparam int DIM = 16;
  localparam int CW  = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [CW-1:0] poseX, poseY;
  logic          RD, WR, Dout;
  logic          Din;
  logic          ldValid;
  logic [CW-1:0] ldRow;
  logic [DIM-1:0] ldData;
  logic          ldReady;
  logic          clrStart;
  logic          Ready;

  int total = 0;
  int bad   = 0;

  maze_map_memory #(.MAP_DIM(DIM), .COORD_W(CW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .poseX    (poseX),
    .poseY    (poseY),
    .RD       (RD),
    .WR       (WR),
    .Dout     (Dout),
    .Din      (Din),
    .ldValid  (ldValid),
    .ldRow    (ldRow),
    .ldData   (ldData),
    .ldReady  (ldReady),
    .clrStart (clrStart),
    .Ready    (Ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd_cell(input int x, input int y);
    poseX = CW'(x);
    poseY = CW'(y);
    RD    = 1'b1;
    step();
    RD    = 1'b0;
  endtask

  task automatic wr_cell(input int x, input int y, input logic v);
    poseX = CW'(x);
    poseY = CW'(y);
    Dout  = v;
    WR    = 1'b1;
    step();
    WR    = 1'b0;
  endtask

  task automatic load_row(input int r, input logic [DIM-1:0] d);
    ldValid = 1'b1;
    ldRow   = CW'(r);
    ldData  = d;
    step();
    ldValid = 1'b0;
  endtask

  initial begin
    RST = 1'b0; RD = 1'b0; WR = 1'b0; Dout = 1'b0;
    poseX = '0; poseY = '0;
    ldValid = 1'b0; ldRow = '0; ldData = '0; clrStart = 1'b0;
    #1;
    check("reset_ready",   16'(Ready),   16'd1);
    check("reset_ldready", 16'(ldReady), 16'd1);
    check("reset_din",     16'(Din),     16'd0);
    #2 RST = 1'b1;
    step();

    // Pattern load: row r = A5A5 ^ r.
    for (int r = 0; r < DIM; r++) load_row(r, 16'hA5A5 ^ 16'(r));
    rd_cell(3, 2);   check("rd_3_2",   16'(Din), 16'd0);  // A5A7 bit3
    rd_cell(0, 0);   check("rd_0_0",   16'(Din), 16'd1);  // A5A5 bit0
    rd_cell(5, 4);   check("rd_5_4",   16'(Din), 16'd1);  // A5A1 bit5
    rd_cell(15, 15); check("rd_15_15", 16'(Din), 16'd1);  // A5AA bit15

    // Mouse write then read back, both polarities.
    wr_cell(15, 15, 1'b0); rd_cell(15, 15); check("wr0_15_15", 16'(Din), 16'd0);
    wr_cell(15, 15, 1'b1); rd_cell(15, 15); check("wr1_15_15", 16'(Din), 16'd1);

    // Same-edge read and write of (4,4): old 0, new 1.
    poseX = 4'd4; poseY = 4'd4; Dout = 1'b1; RD = 1'b1; WR = 1'b1;
    step();
    RD = 1'b0; WR = 1'b0;
    check("rdwr_old_4_4", 16'(Din), 16'd0);
    rd_cell(4, 4); check("reread_4_4", 16'(Din), 16'd1);

    // Din holds across idle cycles and across writes without a read.
    step(); step();
    wr_cell(4, 4, 1'b0);
    check("din_hold", 16'(Din), 16'd1);

    // Row load and mouse write to the same row on one edge.
    ldValid = 1'b1; ldRow = 4'd6; ldData = 16'h0000;
    poseX = 4'd6; poseY = 4'd6; Dout = 1'b1; WR = 1'b1;
    step();
    ldValid = 1'b0; WR = 1'b0;
    rd_cell(6, 6); check("ld_wr_win_6_6", 16'(Din), 16'd1);
    rd_cell(7, 6); check("ld_other_7_6",  16'(Din), 16'd0);

    // Full-ones load, then clear coincident with a load offer and a read.
    for (int r = 0; r < DIM; r++) load_row(r, 16'hFFFF);
    clrStart = 1'b1; ldValid = 1'b1; ldRow = 4'd3; ldData = 16'h0000;
    poseX = 4'd1; poseY = 4'd1; RD = 1'b1;
    #1;
    check("clr_ldready_refused", 16'(ldReady), 16'd0);
    check("clr_ready_still_idle", 16'(Ready),  16'd1);
    step();
    ldValid = 1'b0; RD = 1'b0;
    check("clr_coincident_rd", 16'(Din), 16'd1);
    // Keep clrStart high and hammer RD/WR for the whole window.
    poseX = 4'd2; poseY = 4'd2; Dout = 1'b1; WR = 1'b1; RD = 1'b1;
    for (int i = 0; i < DIM; i++) begin
      check("clr_ready_low",   16'(Ready),   16'd0);
      check("clr_ldready_low", 16'(ldReady), 16'd0);
      if (i == DIM - 1) begin
        clrStart = 1'b0; WR = 1'b0; RD = 1'b0;
      end
      step();
    end
    check("clr_done_ready", 16'(Ready), 16'd1);
    check("clr_rd_dropped", 16'(Din),   16'd1);
    rd_cell(2, 2);   check("clr_wr_dropped_2_2", 16'(Din), 16'd0);
    rd_cell(0, 3);   check("clr_zero_0_3",       16'(Din), 16'd0);
    rd_cell(15, 15); check("clr_zero_15_15",     16'(Din), 16'd0);
    rd_cell(9, 0);   check("clr_zero_9_0",       16'(Din), 16'd0);

    // Reset in the middle of a clear.
    for (int r = 0; r < DIM; r++) load_row(r, 16'hFFFF);
    rd_cell(8, 8); check("pre_rst_rd", 16'(Din), 16'd1);
    clrStart = 1'b1;
    step();                       // now in CLEAR cycle 0
    clrStart = 1'b0;
    for (int i = 0; i < 7; i++) step();  // CLEAR cycle 7
    check("mid_clear_busy", 16'(Ready), 16'd0);
    #2 RST = 1'b0;
    #1;
    check("rst_ready",   16'(Ready),   16'd1);
    check("rst_ldready", 16'(ldReady), 16'd1);
    check("rst_din",     16'(Din),     16'd0);
    #1 RST = 1'b1;
    step();
    for (int y = 0; y < DIM; y++) begin
      for (int x = 0; x < DIM; x++) begin
        rd_cell(x, y);
        check("rst_cell_zero", 16'(Din), 16'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_maze_map_memory
